hazard_unit_mc: RTL and testbench

//  Second-generation hazard unit for the 5-stage ARM pipeline. Compares register

---
 rtl/hazard_unit_mc_if.sv | 39 +++
 rtl/hazard_unit_mc.sv | 152 +++++++++++++++
 tb/tb_hazard_unit_mc.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_mc_if.sv
// Pipeline <-> hazard unit signal bundle: register addresses, write enables,
// memory handshake and PC-write flags in; forwarding selects, stall/flush
// controls and event counters out.
interface hazard_unit_mc_if #(
    parameter int RA_W  = 4,
    parameter int CNT_W = 16
);
    logic [RA_W-1:0]  RA1D, RA2D, RA1E, RA2E;
    logic [RA_W-1:0]  WA3E, WA3M, WA3W;
    logic             RegWriteE, RegWriteM, RegWriteW;
    logic             MemtoRegE;
    logic             MemReqM, MemAckM;
    logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic             BranchTakenE;

    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic             MemErr;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    // Pipeline side: drives hazard sources, consumes controls.
    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
        output MemReqM, MemAckM, PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, FlushW, MemErr, StallCnt, FlushCnt
    );

    // Hazard unit side.
    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE,
        input  MemReqM, MemAckM, PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, FlushW, MemErr, StallCnt, FlushCnt
    );
endinterface

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage pipeline: operand forwarding, load-use and
// PC-write stalls/flushes, a data-memory wait FSM with timeout, and
// saturating stall/flush event counters.
module hazard_unit_mc #(
    parameter int RA_W    = 4,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input logic              clk,
    input logic              reset,   // asynchronous, active-low
    hazard_unit_mc_if.slave  hz
);
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    // The wait counter holds the number of stall cycles already spent on the
    // current access (0 in IDLE), so it never needs to exceed TIMEOUT-1.
    localparam int             WC_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic             mem_err_q, mem_err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       ld_stall, pc_wr_pend, mem_busy, timeout_hit, mem_stall;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_f, stall_d, stall_e, stall_m;
    logic       flush_d, flush_e, flush_w;

    // Forwarding selects: the younger result in M wins over the one in W.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (hz.RegWriteM && (hz.WA3M == hz.RA1E))      fwd_a = 2'b10;
        else if (hz.RegWriteW && (hz.WA3W == hz.RA1E)) fwd_a = 2'b01;
        if (hz.RegWriteM && (hz.WA3M == hz.RA2E))      fwd_b = 2'b10;
        else if (hz.RegWriteW && (hz.WA3W == hz.RA2E)) fwd_b = 2'b01;
    end

    assign ld_stall    = hz.MemtoRegE && hz.RegWriteE &&
                         ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));
    assign pc_wr_pend  = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
    assign mem_busy    = (state_q == S_WAIT) || hz.MemReqM;
    assign timeout_hit = mem_busy && (wait_cnt_q == WC_LAST);
    // Gated by reset so an access interrupted by reset releases the pipe at once.
    assign mem_stall   = reset && mem_busy && !hz.MemAckM && !timeout_hit;

    // Stall/flush controls: a memory wait freezes F..M and bubbles W; the
    // frozen stages keep their hazards, which are re-evaluated on release.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else begin
            stall_f = ld_stall || pc_wr_pend;
            stall_d = ld_stall;
            flush_d = pc_wr_pend || hz.PCSrcW || hz.BranchTakenE;
            flush_e = ld_stall || hz.BranchTakenE;
        end
    end

    // Memory wait FSM next state, wait counter and sticky timeout error.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        mem_err_d  = mem_err_q;
        case (state_q)
            S_IDLE: begin
                wait_cnt_d = '0;
                if (mem_stall) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_stall) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end else begin
                    state_d    = S_IDLE;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = S_IDLE;
                wait_cnt_d = '0;
            end
        endcase
        if (timeout_hit && !hz.MemAckM) begin
            mem_err_d = 1'b1;
        end
    end

    // Event counters stop at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_f && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if ((flush_d || flush_e) && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            mem_err_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_err_q   <= mem_err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.ForwardAE = fwd_a;
    assign hz.ForwardBE = fwd_b;
    assign hz.StallF    = stall_f;
    assign hz.StallD    = stall_d;
    assign hz.StallE    = stall_e;
    assign hz.StallM    = stall_m;
    assign hz.FlushD    = flush_d;
    assign hz.FlushE    = flush_e;
    assign hz.FlushW    = flush_w;
    assign hz.MemErr    = mem_err_q;
    assign hz.StallCnt  = stall_cnt_q;
    assign hz.FlushCnt  = flush_cnt_q;
endmodule

// File: tb/tb_hazard_unit_mc.sv
// Bench for hazard_unit_mc. Two instances: A (TIMEOUT=16, 16-bit counters)
// for forwarding/stall/flush behaviour, B (TIMEOUT=4, 2-bit counters) for
// timeout, sticky error, reset mid-wait and counter saturation. Stimulus
// pushes hand-computed expectations into a queue; a monitor on the falling
// edge pops and compares.
module tb_hazard_unit_mc;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_unit_mc_if #(.RA_W(4), .CNT_W(16)) if_a ();
    hazard_unit_mc_if #(.RA_W(4), .CNT_W(2))  if_b ();

    hazard_unit_mc #(.RA_W(4), .TIMEOUT(16), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .hz(if_a.slave));
    hazard_unit_mc #(.RA_W(4), .TIMEOUT(4), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .hz(if_b.slave));

    typedef struct packed {
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic rwe, rwm, rww, m2re, reqm, ackm, pcd, pce, pcm, pcw, bte;
    } vin_t;

    // ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
    typedef struct packed {
        logic [1:0]  fa, fb;
        logic [6:0]  ctl;
        logic        err;
        logic [15:0] scnt, fcnt;
    } obs_t;

    typedef struct {
        string name;
        int    sel;
        obs_t  want;
    } sb_t;

    localparam logic [6:0] NONE = 7'b0000000;
    localparam logic [6:0] MEM  = 7'b1111001;
    localparam logic [6:0] LD   = 7'b1100010;
    localparam logic [6:0] BR   = 7'b0000110;
    localparam logic [6:0] PCD  = 7'b1000100;
    localparam logic [6:0] PCW  = 7'b0000100;
    localparam logic [1:0] F00  = 2'b00;
    localparam logic [1:0] F01  = 2'b01;
    localparam logic [1:0] F10  = 2'b10;

    vin_t va, vb, v;
    obs_t obs_a, obs_b, act;
    sb_t  sb[$];
    sb_t  cur;
    int   total = 0;
    int   bad   = 0;

    assign {if_a.RA1D, if_a.RA2D, if_a.RA1E, if_a.RA2E, if_a.WA3E, if_a.WA3M, if_a.WA3W,
            if_a.RegWriteE, if_a.RegWriteM, if_a.RegWriteW, if_a.MemtoRegE,
            if_a.MemReqM, if_a.MemAckM, if_a.PCSrcD, if_a.PCSrcE, if_a.PCSrcM,
            if_a.PCSrcW, if_a.BranchTakenE} = va;
    assign {if_b.RA1D, if_b.RA2D, if_b.RA1E, if_b.RA2E, if_b.WA3E, if_b.WA3M, if_b.WA3W,
            if_b.RegWriteE, if_b.RegWriteM, if_b.RegWriteW, if_b.MemtoRegE,
            if_b.MemReqM, if_b.MemAckM, if_b.PCSrcD, if_b.PCSrcE, if_b.PCSrcM,
            if_b.PCSrcW, if_b.BranchTakenE} = vb;

    assign obs_a = {if_a.ForwardAE, if_a.ForwardBE,
                    {if_a.StallF, if_a.StallD, if_a.StallE, if_a.StallM,
                     if_a.FlushD, if_a.FlushE, if_a.FlushW},
                    if_a.MemErr, if_a.StallCnt, if_a.FlushCnt};
    assign obs_b = {if_b.ForwardAE, if_b.ForwardBE,
                    {if_b.StallF, if_b.StallD, if_b.StallE, if_b.StallM,
                     if_b.FlushD, if_b.FlushE, if_b.FlushW},
                    if_b.MemErr, 14'd0, if_b.StallCnt, 14'd0, if_b.FlushCnt};

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            cur = sb.pop_front();
            act = (cur.sel == 0) ? obs_a : obs_b;
            total++;
            if (act !== cur.want) begin
                bad++;
                $display("FAIL %s: got fa=%b fb=%b ctl=%b err=%b scnt=%0d fcnt=%0d, want fa=%b fb=%b ctl=%b err=%b scnt=%0d fcnt=%0d",
                         cur.name, act.fa, act.fb, act.ctl, act.err, act.scnt, act.fcnt,
                         cur.want.fa, cur.want.fb, cur.want.ctl, cur.want.err,
                         cur.want.scnt, cur.want.fcnt);
            end
        end
    end

    // Drive one cycle of stimulus to the selected instance (the other idles)
    // and queue the expected observation for that cycle.
    task automatic cyc(input int sel, input logic rst, input vin_t vin, input string name,
                       input logic [1:0] fa, input logic [1:0] fb, input logic [6:0] ctl,
                       input logic err, input int s, input int f);
        sb_t e;
        @(posedge clk);
        #1;
        reset = rst;
        if (sel == 0) begin
            va = vin;
            vb = '0;
        end else begin
            vb = vin;
            va = '0;
        end
        e.name = name;
        e.sel  = sel;
        e.want = {fa, fb, ctl, err, 16'(s), 16'(f)};
        sb.push_back(e);
    endtask

    initial begin
        reset = 1'b0;
        va = '0;
        vb = '0;

        v = '0;
        cyc(0, 1'b0, v, "reset_a", F00, F00, NONE, 1'b0, 0, 0);
        cyc(1, 1'b0, v, "reset_b", F00, F00, NONE, 1'b0, 0, 0);
        cyc(0, 1'b1, v, "idle_a",  F00, F00, NONE, 1'b0, 0, 0);

        // Forwarding
        v = '0; v.rwm = 1; v.wa3m = 3; v.rww = 1; v.wa3w = 3; v.ra1e = 3;
        cyc(0, 1'b1, v, "fwd_m_beats_w", F10, F00, NONE, 1'b0, 0, 0);
        v.rwm = 0;
        cyc(0, 1'b1, v, "fwd_w_only", F01, F00, NONE, 1'b0, 0, 0);
        v = '0; v.rwm = 1; v.wa3m = 3; v.rww = 1; v.wa3w = 7; v.ra1e = 3; v.ra2e = 7;
        cyc(0, 1'b1, v, "fwd_split", F10, F01, NONE, 1'b0, 0, 0);
        v.rwm = 0; v.rww = 0;
        cyc(0, 1'b1, v, "fwd_no_write", F00, F00, NONE, 1'b0, 0, 0);

        // Load-use
        v = '0; v.m2re = 1; v.rwe = 1; v.wa3e = 5; v.ra2d = 5;
        cyc(0, 1'b1, v, "ld_use_rb", F00, F00, LD, 1'b0, 0, 0);
        v = '0;
        cyc(0, 1'b1, v, "ld_use_cnt", F00, F00, NONE, 1'b0, 1, 1);
        v = '0; v.m2re = 1; v.rwe = 1; v.wa3e = 5; v.ra1d = 5;
        cyc(0, 1'b1, v, "ld_use_ra", F00, F00, LD, 1'b0, 1, 1);
        v.m2re = 0;
        cyc(0, 1'b1, v, "not_load", F00, F00, NONE, 1'b0, 2, 2);
        v = '0; v.m2re = 1; v.wa3e = 5; v.ra2d = 5;
        cyc(0, 1'b1, v, "load_no_regwrite", F00, F00, NONE, 1'b0, 2, 2);

        // Memory wait released by ack
        v = '0; v.reqm = 1;
        cyc(0, 1'b1, v, "mem_w0", F00, F00, MEM, 1'b0, 2, 2);
        cyc(0, 1'b1, v, "mem_w1", F00, F00, MEM, 1'b0, 3, 2);
        cyc(0, 1'b1, v, "mem_w2", F00, F00, MEM, 1'b0, 4, 2);
        v.ackm = 1;
        cyc(0, 1'b1, v, "mem_ack", F00, F00, NONE, 1'b0, 5, 2);
        v = '0;
        cyc(0, 1'b1, v, "mem_done", F00, F00, NONE, 1'b0, 5, 2);
        v.reqm = 1; v.ackm = 1;
        cyc(0, 1'b1, v, "mem_same_cycle_ack", F00, F00, NONE, 1'b0, 5, 2);
        v = '0;
        cyc(0, 1'b1, v, "mem_stayed_idle", F00, F00, NONE, 1'b0, 5, 2);

        // Branch resolved while frozen
        v = '0; v.reqm = 1; v.bte = 1;
        cyc(0, 1'b1, v, "br_frozen0", F00, F00, MEM, 1'b0, 5, 2);
        cyc(0, 1'b1, v, "br_frozen1", F00, F00, MEM, 1'b0, 6, 2);
        v.ackm = 1;
        cyc(0, 1'b1, v, "br_release", F00, F00, BR, 1'b0, 7, 2);
        v = '0;
        cyc(0, 1'b1, v, "br_flush_cnt", F00, F00, NONE, 1'b0, 7, 3);

        // PC writes in flight
        v = '0; v.pcd = 1;
        cyc(0, 1'b1, v, "pc_d", F00, F00, PCD, 1'b0, 7, 3);
        v = '0; v.pce = 1;
        cyc(0, 1'b1, v, "pc_e", F00, F00, PCD, 1'b0, 8, 4);
        v = '0; v.pcm = 1;
        cyc(0, 1'b1, v, "pc_m", F00, F00, PCD, 1'b0, 9, 5);
        v = '0; v.pcw = 1;
        cyc(0, 1'b1, v, "pc_w", F00, F00, PCW, 1'b0, 10, 6);
        v = '0;
        cyc(0, 1'b1, v, "pc_cnt", F00, F00, NONE, 1'b0, 10, 7);

        // Load-use hidden by a memory wait, seen after release
        v = '0; v.reqm = 1; v.m2re = 1; v.rwe = 1; v.wa3e = 5; v.ra2d = 5;
        cyc(0, 1'b1, v, "ld_frozen", F00, F00, MEM, 1'b0, 10, 7);
        v.ackm = 1;
        cyc(0, 1'b1, v, "ld_after_ack", F00, F00, LD, 1'b0, 11, 7);
        v = '0;
        cyc(0, 1'b1, v, "ld_after_cnt", F00, F00, NONE, 1'b0, 12, 8);

        // Instance B: timeout after 3 stall cycles, sticky error
        v = '0; v.reqm = 1;
        cyc(1, 1'b1, v, "to_w0", F00, F00, MEM, 1'b0, 0, 0);
        cyc(1, 1'b1, v, "to_w1", F00, F00, MEM, 1'b0, 1, 0);
        cyc(1, 1'b1, v, "to_w2", F00, F00, MEM, 1'b0, 2, 0);
        cyc(1, 1'b1, v, "to_release", F00, F00, NONE, 1'b0, 3, 0);
        v = '0;
        cyc(1, 1'b1, v, "to_err_set", F00, F00, NONE, 1'b1, 3, 0);
        cyc(1, 1'b1, v, "to_err_sticky", F00, F00, NONE, 1'b1, 3, 0);

        // Reset in the middle of a wait; stall counter saturates before it
        v.reqm = 1;
        cyc(1, 1'b1, v, "pre_rst_w0", F00, F00, MEM, 1'b1, 3, 0);
        cyc(1, 1'b1, v, "stall_cnt_sat", F00, F00, MEM, 1'b1, 3, 0);
        cyc(1, 1'b0, v, "rst_mid_wait", F00, F00, NONE, 1'b0, 0, 0);
        v = '0;
        cyc(1, 1'b1, v, "rst_left_idle", F00, F00, NONE, 1'b0, 0, 0);

        // Wait counter restarts from zero after reset
        v.reqm = 1;
        cyc(1, 1'b1, v, "to2_w0", F00, F00, MEM, 1'b0, 0, 0);
        cyc(1, 1'b1, v, "to2_w1", F00, F00, MEM, 1'b0, 1, 0);
        cyc(1, 1'b1, v, "to2_w2", F00, F00, MEM, 1'b0, 2, 0);
        cyc(1, 1'b1, v, "to2_release", F00, F00, NONE, 1'b0, 3, 0);
        v = '0;
        cyc(1, 1'b1, v, "to2_err", F00, F00, NONE, 1'b1, 3, 0);

        // Flush counter saturation
        v.bte = 1;
        cyc(1, 1'b1, v, "fl0", F00, F00, BR, 1'b1, 3, 0);
        cyc(1, 1'b1, v, "fl1", F00, F00, BR, 1'b1, 3, 1);
        cyc(1, 1'b1, v, "fl2", F00, F00, BR, 1'b1, 3, 2);
        cyc(1, 1'b1, v, "fl3", F00, F00, BR, 1'b1, 3, 3);
        v = '0;
        cyc(1, 1'b1, v, "flush_cnt_sat", F00, F00, NONE, 1'b1, 3, 3);

        repeat (4) @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
